// File: rtl/rah_stream_demux.sv
// rah_stream_demux: parses length-framed headers from the MIPI word stream and steers payload into per-app FIFOs.
// Latency: a word accepted at edge N shows in empty/count after N; pops return rd_data one edge later; pulses are registered.
// Backpressure: none on the input stream; full FIFOs drop words and set error. Optional macro RAH_DEMUX_PKT_DROP_EN adds whole-packet admission.

module rah_sync_fifo #(
    parameter int W         = 32,
    parameter int DEPTH     = 64,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_req,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       empty,
    output logic                       almost_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_nxt;
    logic          full;
    logic          wr_en;
    logic          rd_en;

    // Full comes from the registered count, so a same-cycle pop never rescues a write at full.
    assign full  = (cnt == CW'(DEPTH));
    assign wr_en = push_vld && !full;
    assign rd_en = pop_req && !empty;

    always_comb begin
        cnt_nxt = cnt;
        case ({wr_en, rd_en})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            pop_dat      <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + AW'(1);
                pop_dat <= mem[rd_ptr];
            end
            cnt          <= cnt_nxt;
            empty        <= (cnt_nxt == '0);
            almost_empty <= (32'(cnt_nxt) <= 32'(AE_THRESH));
        end
    end
endmodule

module rah_stream_demux #(
    parameter int           DATA_WIDTH          = 32,
    parameter int           NUM_APPS            = 4,
    parameter int           FIFO_DEPTH          = 64,
    parameter int           ALMOST_EMPTY_THRESH = 2,
    parameter logic [7:0]   HDR_MARKER          = 8'hA5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          mipi_data,
    input  logic                           mipi_rx_valid,
    input  logic [NUM_APPS-1:0]            request_data,
    input  logic [NUM_APPS-1:0]            error_clr,
    output logic [NUM_APPS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_APPS-1:0]            data_queue_empty,
    output logic [NUM_APPS-1:0]            data_queue_almost_empty,
    output logic                           end_of_packet,
    output logic                           bad_header,
    output logic [NUM_APPS-1:0]            error
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [7:0]  marker;
        logic [15:0] len;
        logic [7:0]  id;
    } hdr_t;

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_t;

    state_t        state, state_nxt;
    logic [15:0]   rem, rem_nxt;
    logic [7:0]    cur_id, cur_id_nxt;
    hdr_t          hdr;
    logic          id_ok;
    logic          wr_pay;
    logic          adm_drop;
    logic          eop_nxt;
    logic          bad_nxt;

    logic [NUM_APPS-1:0] push;
    logic [NUM_APPS-1:0] full;
    logic [NUM_APPS-1:0] err_set;
    logic [CW-1:0]       cnt [NUM_APPS];

    assign hdr   = mipi_data[31:0];
    assign id_ok = ({1'b0, hdr.id} < 9'(NUM_APPS));

`ifdef RAH_DEMUX_PKT_DROP_EN
    logic [CW-1:0] cnt_sel;
    logic [16:0]   free_sel;

    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            if (hdr.id == 8'(i)) begin
                cnt_sel = cnt[i];
            end
        end
    end

    // LEN > FIFO_DEPTH can never fit, so it falls out of the same comparison.
    assign free_sel = 17'(FIFO_DEPTH) - 17'(cnt_sel);
`endif

    always_comb begin
        state_nxt  = state;
        rem_nxt    = rem;
        cur_id_nxt = cur_id;
        wr_pay     = 1'b0;
        adm_drop   = 1'b0;
        eop_nxt    = 1'b0;
        bad_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mipi_rx_valid) begin
                    if (hdr.marker != HDR_MARKER || hdr.len == 16'd0) begin
                        bad_nxt = 1'b1;
                    end else if (!id_ok) begin
                        bad_nxt   = 1'b1;
                        rem_nxt   = hdr.len;
                        state_nxt = S_DROP;
                    end else begin
                        rem_nxt    = hdr.len;
                        cur_id_nxt = hdr.id;
`ifdef RAH_DEMUX_PKT_DROP_EN
                        if (17'(hdr.len) > free_sel) begin
                            adm_drop  = 1'b1;
                            state_nxt = S_DROP;
                        end else begin
                            state_nxt = S_PAYLOAD;
                        end
`else
                        state_nxt = S_PAYLOAD;
`endif
                    end
                end
            end
            S_PAYLOAD: begin
                if (mipi_rx_valid) begin
                    wr_pay  = 1'b1;
                    rem_nxt = rem - 16'd1;
                    if (rem == 16'd1) begin
                        eop_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (mipi_rx_valid) begin
                    rem_nxt = rem - 16'd1;
                    if (rem == 16'd1) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        push    = '0;
        err_set = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            push[i]    = wr_pay && (cur_id == 8'(i));
            err_set[i] = (push[i] && full[i]) || (adm_drop && hdr.id == 8'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rem           <= '0;
            cur_id        <= '0;
            end_of_packet <= 1'b0;
            bad_header    <= 1'b0;
            error         <= '0;
        end else begin
            state         <= state_nxt;
            rem           <= rem_nxt;
            cur_id        <= cur_id_nxt;
            end_of_packet <= eop_nxt;
            bad_header    <= bad_nxt;
            // Set wins over a same-cycle clear.
            error         <= err_set | (error & ~error_clr);
        end
    end

    for (genvar g = 0; g < NUM_APPS; g++) begin : g_app
        assign full[g] = (cnt[g] == CW'(FIFO_DEPTH));

        rah_sync_fifo #(
            .W         (DATA_WIDTH),
            .DEPTH     (FIFO_DEPTH),
            .AE_THRESH (ALMOST_EMPTY_THRESH)
        ) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .push_vld     (push[g]),
            .push_dat     (mipi_data),
            .pop_req      (request_data[g]),
            .pop_dat      (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .cnt          (cnt[g]),
            .empty        (data_queue_empty[g]),
            .almost_empty (data_queue_almost_empty[g])
        );
    end
endmodule

// File: tb/tb_rah_stream_demux.sv
// Bench for rah_stream_demux: directed scenarios then randomized traffic, all checked against a queue-based packet model.
module tb_rah_stream_demux;
    localparam int NA    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AE    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   mipi_data = '0;
    logic            mipi_rx_valid = 1'b0;
    logic [NA-1:0]   request_data = '0;
    logic [NA-1:0]   error_clr = '0;
    logic [NA*DW-1:0] rd_data;
    logic [NA-1:0]   data_queue_empty;
    logic [NA-1:0]   data_queue_almost_empty;
    logic            end_of_packet;
    logic            bad_header;
    logic [NA-1:0]   error;

    rah_stream_demux #(
        .DATA_WIDTH          (DW),
        .NUM_APPS            (NA),
        .FIFO_DEPTH          (DEPTH),
        .ALMOST_EMPTY_THRESH (AE),
        .HDR_MARKER          (8'hA5)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .mipi_data               (mipi_data),
        .mipi_rx_valid           (mipi_rx_valid),
        .request_data            (request_data),
        .error_clr               (error_clr),
        .rd_data                 (rd_data),
        .data_queue_empty        (data_queue_empty),
        .data_queue_almost_empty (data_queue_almost_empty),
        .end_of_packet           (end_of_packet),
        .bad_header              (bad_header),
        .error                   (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per app plus packet-framing bookkeeping.
    logic [31:0] mq [NA][$];
    int          m_mode = 0;   // 0 = expecting header, 1 = payload, 2 = discarding
    int          m_rem  = 0;
    int          m_app  = 0;
    logic [31:0] exp_rd [NA];
    logic        exp_eop = 1'b0;
    logic        exp_bad = 1'b0;
    logic [NA-1:0] exp_err = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int sz [NA];
        logic [NA-1:0] set_mask;
        int push_app;
        logic [7:0] mk;
        int len, id;
        if (rst) begin
            for (int i = 0; i < NA; i++) begin
                mq[i].delete();
                exp_rd[i] = '0;
            end
            m_mode = 0; m_rem = 0;
            exp_eop = 1'b0; exp_bad = 1'b0; exp_err = '0;
            return;
        end
        for (int i = 0; i < NA; i++) sz[i] = mq[i].size();
        set_mask = '0;
        push_app = -1;
        exp_eop  = 1'b0;
        exp_bad  = 1'b0;
        if (mipi_rx_valid) begin
            if (m_mode == 0) begin
                mk  = mipi_data[31:24];
                len = int'(mipi_data[23:8]);
                id  = int'(mipi_data[7:0]);
                if (mk != 8'hA5 || len == 0) begin
                    exp_bad = 1'b1;
                end else if (id >= NA) begin
                    exp_bad = 1'b1; m_rem = len; m_mode = 2;
                end else begin
                    m_rem = len; m_app = id; m_mode = 1;
`ifdef RAH_DEMUX_PKT_DROP_EN
                    if (len > DEPTH - sz[id]) begin
                        m_mode = 2;
                        set_mask[id] = 1'b1;
                    end
`endif
                end
            end else begin
                if (m_mode == 1) push_app = m_app;
                m_rem--;
                if (m_rem == 0) begin
                    if (m_mode == 1) exp_eop = 1'b1;
                    m_mode = 0;
                end
            end
        end
        for (int i = 0; i < NA; i++) begin
            if (request_data[i] && sz[i] > 0) exp_rd[i] = mq[i].pop_front();
        end
        if (push_app >= 0) begin
            if (sz[push_app] >= DEPTH) set_mask[push_app] = 1'b1;
            else mq[push_app].push_back(mipi_data);
        end
        for (int i = 0; i < NA; i++) begin
            if (set_mask[i]) exp_err[i] = 1'b1;
            else if (error_clr[i]) exp_err[i] = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [127:0] bus;
        logic [NA-1:0] e, ae;
        bus = '0;
        for (int i = 0; i < NA; i++) begin
            bus[i*DW +: DW] = exp_rd[i];
            e[i]  = (mq[i].size() == 0);
            ae[i] = (mq[i].size() <= AE);
        end
        chk("rd_data", 128'(rd_data), bus);
        chk("empty", 128'(data_queue_empty), 128'(e));
        chk("almost_empty", 128'(data_queue_almost_empty), 128'(ae));
        chk("end_of_packet", 128'(end_of_packet), 128'(exp_eop));
        chk("bad_header", 128'(bad_header), 128'(exp_bad));
        chk("error", 128'(error), 128'(exp_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [NA-1:0] rq,
                         input logic [NA-1:0] clr, input logic r);
        mipi_rx_valid = v;
        mipi_data     = d;
        request_data  = rq;
        error_clr     = clr;
        rst           = r;
        tick();
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] mk, input int len, input int id);
        return {mk, 16'(len), 8'(id)};
    endfunction

    initial begin
        int gen_rem;
        logic [7:0] mk;
        int len, id, r;
        logic [31:0] w;
        logic v;
        logic [NA-1:0] rq, clr;

        for (int i = 0; i < NA; i++) exp_rd[i] = '0;
        drive(1'b0, '0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b0);

        // Basic three-word packet to app 1, then drain it.
        drive(1'b1, hdr(8'hA5, 3, 1), '0, '0, 1'b0);
        drive(1'b1, 32'd10, '0, '0, 1'b0);
        drive(1'b1, 32'd11, '0, '0, 1'b0);
        drive(1'b1, 32'd12, '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, '0, 4'b0010, '0, 1'b0);

        // Bad marker, then a good one-word packet to app 0.
        drive(1'b1, hdr(8'h5A, 1, 0), '0, '0, 1'b0);
        drive(1'b1, hdr(8'hA5, 1, 0), '0, '0, 1'b0);
        drive(1'b1, 32'd77, '0, '0, 1'b0);

        // Out-of-range id: payload discarded, next word is a header.
        drive(1'b1, hdr(8'hA5, 2, 7), '0, '0, 1'b0);
        drive(1'b1, 32'hDEAD0001, '0, '0, 1'b0);
        drive(1'b1, 32'hDEAD0002, '0, '0, 1'b0);
        drive(1'b1, hdr(8'hA5, 1, 3), '0, '0, 1'b0);
        drive(1'b1, 32'd33, '0, '0, 1'b0);

        // Oversized packet into a depth-4 FIFO, no pops.
        drive(1'b1, hdr(8'hA5, 6, 2), '0, '0, 1'b0);
        for (int k = 0; k < 6; k++) drive(1'b1, 32'(200 + k), '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, '0, 4'b1111, '0, 1'b0);
        drive(1'b0, '0, '0, 4'b0100, 1'b0);

        // Reset mid-packet.
        drive(1'b1, hdr(8'hA5, 5, 0), '0, '0, 1'b0);
        drive(1'b1, 32'd55, '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1);
        drive(1'b1, hdr(8'hA5, 1, 1), '0, '0, 1'b0);
        drive(1'b1, 32'd66, '0, '0, 1'b0);

        // App 0 holding two words, then push and pop together.
        drive(1'b1, hdr(8'hA5, 3, 0), '0, '0, 1'b0);
        drive(1'b1, 32'd1, '0, '0, 1'b0);
        drive(1'b1, 32'd2, '0, '0, 1'b0);
        drive(1'b1, 32'd3, 4'b0001, '0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, '0, 4'b0011, '0, 1'b0);

        // Randomized traffic.
        gen_rem = 0;
        for (int c = 0; c < 3000; c++) begin
            v = ($urandom_range(0, 3) != 0);
            w = '0;
            if (v) begin
                if (gen_rem == 0) begin
                    r   = int'($urandom_range(0, 19));
                    mk  = 8'hA5;
                    len = int'($urandom_range(1, 6));
                    id  = int'($urandom_range(0, NA - 1));
                    if (r == 0) mk = 8'(($urandom_range(0, 254) + 8'hA6) & 8'hFF);
                    if (r == 1) len = 0;
                    if (r == 2) id = int'($urandom_range(NA, 255));
                    w = hdr(mk, len, id);
                    gen_rem = (mk == 8'hA5 && len != 0) ? len : 0;
                end else begin
                    w = $urandom;
                    gen_rem--;
                end
            end
            for (int i = 0; i < NA; i++) begin
                rq[i]  = ($urandom_range(0, 2) == 0);
                clr[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 299) == 0) begin
                gen_rem = 0;
                drive(v, w, rq, clr, 1'b1);
            end else begin
                drive(v, w, rq, clr, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
